// File: rtl/xor_mask_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : xor_mask_arbiter
// Description : Round-robin arbiter sharing one registered XOR/mask datapath
//               between N_REQ requesters, with valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module xor_mask_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                req_valid,
  output logic [N_REQ-1:0]                req_ready,
  input  logic [N_REQ*WIDTH-1:0]          req_a,
  input  logic [N_REQ*WIDTH-1:0]          req_b,
  input  logic [WIDTH-1:0]                cfg_mask,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [WIDTH-1:0]                resp_data,
  output logic [$clog2(N_REQ)-1:0]        resp_id
);

  localparam int IDW = $clog2(N_REQ);
  localparam logic [IDW-1:0] C_LAST_INIT = IDW'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDW-1:0]     r_last_grant;
  logic [IDW-1:0]     r_gid;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_mask;
  logic               r_resp_valid;
  logic [WIDTH-1:0]   r_resp_data;
  logic [IDW-1:0]     r_resp_id;

  logic               w_any;
  logic [IDW-1:0]     w_gnt;
  logic [IDW-1:0]     w_cand;
  int                 w_idx;

  // Scan from the farthest candidate down to last_grant+1 so the nearest
  // requester after the previous grant is the one left in w_gnt.
  always_comb begin
    w_any  = 1'b0;
    w_gnt  = '0;
    w_idx  = 0;
    w_cand = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx  = (int'(r_last_grant) + k) % N_REQ;
      w_cand = IDW'(w_idx);
      if (req_valid[w_cand]) begin
        w_any = 1'b1;
        w_gnt = w_cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = (r_state == S_IDLE) && !rst && w_any && (w_gnt == IDW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_id    <= '0;
      r_last_grant <= C_LAST_INIT;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_a          <= req_a[w_gnt*WIDTH +: WIDTH];
            r_b          <= req_b[w_gnt*WIDTH +: WIDTH];
            r_mask       <= cfg_mask;
            r_gid        <= w_gnt;
            r_last_grant <= w_gnt;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_resp_data  <= ((r_a ^ r_b) & r_mask) ^ (r_b & r_mask);
          r_resp_id    <= r_gid;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_id    = r_resp_id;

endmodule
`default_nettype wire

// File: tb/tb_xor_mask_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_xor_mask_arbiter
// Description : Directed plus randomized bench for xor_mask_arbiter against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xor_mask_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [W-1:0]   cfg_mask;
  logic           resp_valid;
  logic           resp_ready;
  logic [W-1:0]   resp_data;
  logic [IW-1:0]  resp_id;

  logic [W-1:0]   a_v [N];
  logic [W-1:0]   b_v [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign req_a[gi*W +: W] = a_v[gi];
    assign req_b[gi*W +: W] = b_v[gi];
  end

  xor_mask_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .cfg_mask   (cfg_mask),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  bit         busy;
  int         age;
  int         last;
  int         exp_id;
  logic [W-1:0] exp_data;
  bit         post_rst;
  bit         reroll;
  int         grants[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int l);
    for (int k = 1; k <= N; k++) begin
      if (v[(l + k) % N]) return (l + k) % N;
    end
    return -1;
  endfunction

  // One clock: drive, check the cycle against the model, then advance the model.
  task automatic cycle(input logic [N-1:0] v, input logic rr, input logic r);
    int           g;
    logic [W-1:0] cand;
    req_valid  = v;
    resp_ready = rr;
    rst        = r;
    #1;
    g    = pick(v, last);
    cand = (g >= 0) ? (a_v[g] & cfg_mask) : '0;
    if (r || busy || g < 0) chk("req_ready_idle", {28'd0, req_ready}, 32'd0);
    else                    chk("req_ready_grant", {28'd0, req_ready}, 32'd1 << g);
    chk("resp_valid", {31'd0, resp_valid}, {31'd0, busy && age >= 2});
    if (busy && age >= 2) begin
      chk("resp_data", {24'd0, resp_data}, {24'd0, exp_data});
      chk("resp_id", {30'd0, resp_id}, exp_id);
    end
    if (post_rst && !busy) begin
      chk("rst_data", {24'd0, resp_data}, 32'd0);
      chk("rst_id", {30'd0, resp_id}, 32'd0);
    end
    @(posedge clk);
    if (r) begin
      busy     = 1'b0;
      last     = N - 1;
      post_rst = 1'b1;
    end else if (busy) begin
      if (age >= 2 && rr) busy = 1'b0;
      else age++;
    end else if (g >= 0) begin
      busy     = 1'b1;
      age      = 1;
      exp_id   = g;
      exp_data = cand;
      last     = g;
      post_rst = 1'b0;
      grants.push_back(g);
    end
    @(negedge clk);
    if (reroll && !r && g >= 0 && grants.size() > 0 && age == 1 && busy) begin
      a_v[g] = W'($urandom);
      b_v[g] = W'($urandom);
    end
  endtask

  initial begin
    busy = 0; age = 0; last = N - 1; exp_id = 0; exp_data = '0;
    post_rst = 0; reroll = 0;
    req_valid = '0; resp_ready = 1'b0; rst = 1'b1; cfg_mask = 8'hFF;
    for (int i = 0; i < N; i++) begin a_v[i] = 8'h11 * i; b_v[i] = 8'h22; end
    @(negedge clk);

    // Reset
    cycle(4'b0000, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b1);
    chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);

    // Basic operation, full mask
    a_v[0] = 8'h5A; b_v[0] = 8'h3C; cfg_mask = 8'hFF;
    cycle(4'b0001, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);
    chk("t1_valid", {31'd0, resp_valid}, 32'd1);
    chk("t1_data", {24'd0, resp_data}, 32'h5A);
    chk("t1_id", {30'd0, resp_id}, 32'd0);
    cycle(4'b0000, 1'b1, 1'b0);

    // Partial mask; mask change during EXEC must not matter
    cfg_mask = 8'h0F;
    cycle(4'b0001, 1'b1, 1'b0);
    cfg_mask = 8'h00;
    cycle(4'b0000, 1'b1, 1'b0);
    chk("t2_data", {24'd0, resp_data}, 32'h0A);
    cycle(4'b0000, 1'b1, 1'b0);

    // Round-robin with all requesters pending
    cfg_mask = 8'hFF;
    cycle(4'b0000, 1'b0, 1'b1);
    grants.delete();
    for (int c = 0; c < 15; c++) cycle(4'b1111, 1'b1, 1'b0);
    chk("t3_count", grants.size(), 32'd5);
    if (grants.size() == 5) begin
      chk("t3_g0", grants[0], 32'd0);
      chk("t3_g1", grants[1], 32'd1);
      chk("t3_g2", grants[2], 32'd2);
      chk("t3_g3", grants[3], 32'd3);
      chk("t3_g4", grants[4], 32'd0);
    end

    // Sparse requesters wrap and skip idle ones
    grants.delete();
    for (int c = 0; c < 6; c++) cycle(4'b0101, 1'b1, 1'b0);
    chk("t4_count", grants.size(), 32'd2);
    if (grants.size() == 2) begin
      chk("t4_g0", grants[0], 32'd2);
      chk("t4_g1", grants[1], 32'd0);
    end

    // Response backpressure
    cycle(4'b0001, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) cycle(4'b1111, 1'b0, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);

    // Reset in EXEC, then in RESP
    cycle(4'b0010, 1'b1, 1'b0);
    cycle(4'b1111, 1'b1, 1'b1);
    chk("t6_exec_valid", {31'd0, resp_valid}, 32'd0);
    grants.delete();
    cycle(4'b1111, 1'b0, 1'b0);
    cycle(4'b1111, 1'b0, 1'b0);
    cycle(4'b1111, 1'b0, 1'b1);
    chk("t6_resp_valid", {31'd0, resp_valid}, 32'd0);
    cycle(4'b1111, 1'b1, 1'b0);
    chk("t6_count", grants.size(), 32'd2);
    if (grants.size() == 2) begin
      chk("t6_g0", grants[0], 32'd0);
      chk("t6_g1", grants[1], 32'd0);
    end
    cycle(4'b0000, 1'b1, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);

    // Randomized traffic
    reroll = 1'b1;
    for (int c = 0; c < 500; c++) begin
      cfg_mask = W'($urandom);
      cycle(N'($urandom), ($urandom % 3) != 0, ($urandom % 60) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
